// File: rtl/bomb_game_ctrl_if.sv
// bomb_game_ctrl_if: player/score-counter side signals of the bomb game sequencer.
// master drives the player inputs and score; slave is the sequencer itself.
interface bomb_game_ctrl_if #(
    parameter int PAT_W = 4
);
    logic             i_Start;
    logic [PAT_W-1:0] i_Switch;
    logic [4:0]       i_Score;
    logic [2:0]       o_State;
    logic             o_Sec1Tick;
    logic             o_Comparison;
    logic [PAT_W-1:0] o_Target;
    logic [5:0]       o_TimeLeft;

    modport master (
        output i_Start,
        output i_Switch,
        output i_Score,
        input  o_State,
        input  o_Sec1Tick,
        input  o_Comparison,
        input  o_Target,
        input  o_TimeLeft
    );

    modport slave (
        input  i_Start,
        input  i_Switch,
        input  i_Score,
        output o_State,
        output o_Sec1Tick,
        output o_Comparison,
        output o_Target,
        output o_TimeLeft
    );
endinterface

// File: rtl/bomb_game_ctrl.sv
// bomb_game_ctrl: game FSM, 1 s tick, fuse timer and LFSR target generator.
// Define BOMB_START_SYNC_EN to synchronise and edge-detect an async i_Start.
module bomb_game_ctrl #(
    parameter int CLK_HZ     = 50000000,
    parameter int TIME_LIMIT = 30,
    parameter int WIN_SCORE  = 20,
    parameter int PAT_W      = 4
) (
    input logic             i_Clk,
    input logic             i_Rst,
    bomb_game_ctrl_if.slave bus
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_HZ - 1);
    localparam logic [5:0]       TL       = 6'(TIME_LIMIT);
    localparam logic [4:0]       WIN      = 5'(WIN_SCORE);
    localparam logic [7:0]       LFSR_SEED = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_START = 3'b001,
        S_CLEAR = 3'b010,
        S_FAIL  = 3'b011
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [5:0]       time_q, time_d;
    logic [PAT_W-1:0] target_q, target_d;
    logic             cmp_q, cmp_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic             st;
    logic             enter;
    logic             run;

`ifdef BOMB_START_SYNC_EN
    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= bus.i_Start;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign st = sync2_q & ~prev_q;
`else
    assign st = bus.i_Start;
`endif

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear is tested first so a last-moment score beats the fuse.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (st) state_d = S_START;
            end
            S_START: begin
                if (bus.i_Score >= WIN) state_d = S_CLEAR;
                else if (time_q == 6'd0) state_d = S_FAIL;
            end
            S_CLEAR, S_FAIL: begin
                if (st) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_State      = state_q;
        bus.o_Sec1Tick   = tick_q;
        bus.o_Comparison = cmp_q;
        bus.o_Target     = target_q;
        bus.o_TimeLeft   = time_q;
    end

    always_comb begin
        lfsr_d = {lfsr_q[6:0],
                  lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        enter  = (state_q == S_IDLE) && st;
        run    = (state_q == S_START) && (state_d == S_START);

        cnt_d = '0;
        if (run) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end
        tick_d = run && (cnt_q == CNT_MAX);

        cmp_d = (bus.i_Switch == target_q);

        time_d   = time_q;
        target_d = target_q;
        if (enter) begin
            time_d   = TL;
            target_d = lfsr_q[PAT_W-1:0];
        end else if (tick_q) begin
            if (time_q != 6'd0) time_d = time_q - 6'd1;
            if (cmp_q) target_d = lfsr_q[PAT_W-1:0];
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            time_q   <= TL;
            target_q <= '0;
            cmp_q    <= 1'b0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            time_q   <= time_d;
            target_q <= target_d;
            cmp_q    <= cmp_d;
            lfsr_q   <= lfsr_d;
        end
    end

endmodule
